// File: rtl/morse_receiver.sv
// Morse receiver: measures tick-sampled mark/space runs and emits one strobe per letter.
// Optional `MORSE_RX_ASCII_EN adds a registered letter_ascii output (A-Z decode, '?' otherwise).
module morse_receiver #(
  parameter int unsigned DOT_MAX    = 2,
  parameter int unsigned DASH_MAX   = 5,
  parameter int unsigned GAP_LETTER = 3,
  parameter int unsigned MAX_ELEMS  = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 tick,
  input  logic                 key_in,
  output logic                 letter_valid,
  output logic [2:0]           letter_len,
  output logic [MAX_ELEMS-1:0] letter_code,
  output logic                 err,
`ifdef MORSE_RX_ASCII_EN
  output logic [7:0]           letter_ascii,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_MAX_C = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(GAP_LETTER);
  localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);
  localparam logic [2:0]       MAX_ELEMS_C = 3'(MAX_ELEMS);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      run_q, run_d;
  logic [MAX_ELEMS-1:0]  elem_q, elem_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [2:0]            len_q, len_d;
  logic [MAX_ELEMS-1:0]  code_q, code_d;

  logic [CNT_W-1:0]      run_inc;
  logic [MAX_ELEMS-1:0]  elem_app;
  logic                  emit;
  logic [2:0]            emit_len;
  logic [MAX_ELEMS-1:0]  emit_code;

`ifdef MORSE_RX_ASCII_EN
  logic [7:0]            ascii_q, ascii_d;

  function automatic logic [7:0] morse_ascii(input logic [2:0] len,
                                             input logic [MAX_ELEMS-1:0] code);
    logic [3:0] c4;
    logic [7:0] res;
    c4 = '0;
    for (int unsigned i = 0; i < MAX_ELEMS; i++) begin
      if (i < 4) c4[i] = code[i];
    end
    // {len, pattern}; pattern bit0 is the first element, 1 = dash
    case ({len, c4})
      7'b010_0010: res = 8'h41; // A
      7'b100_0001: res = 8'h42; // B
      7'b100_0101: res = 8'h43; // C
      7'b011_0001: res = 8'h44; // D
      7'b001_0000: res = 8'h45; // E
      7'b100_0100: res = 8'h46; // F
      7'b011_0011: res = 8'h47; // G
      7'b100_0000: res = 8'h48; // H
      7'b010_0000: res = 8'h49; // I
      7'b100_1110: res = 8'h4A; // J
      7'b011_0101: res = 8'h4B; // K
      7'b100_0010: res = 8'h4C; // L
      7'b010_0011: res = 8'h4D; // M
      7'b010_0001: res = 8'h4E; // N
      7'b011_0111: res = 8'h4F; // O
      7'b100_0110: res = 8'h50; // P
      7'b100_1011: res = 8'h51; // Q
      7'b011_0010: res = 8'h52; // R
      7'b011_0000: res = 8'h53; // S
      7'b001_0001: res = 8'h54; // T
      7'b011_0100: res = 8'h55; // U
      7'b100_1000: res = 8'h56; // V
      7'b011_0110: res = 8'h57; // W
      7'b100_1001: res = 8'h58; // X
      7'b100_1101: res = 8'h59; // Y
      7'b100_0011: res = 8'h5A; // Z
      default:     res = 8'h3F;
    endcase
    return res;
  endfunction
`endif

  // Saturating increment and the pattern with the just-ended mark appended
  always_comb begin
    run_inc  = (run_q == '1) ? run_q : run_q + RUN_ONE;
    elem_app = elem_q;
    for (int unsigned i = 0; i < MAX_ELEMS; i++) begin
      if (i == 32'(cnt_q)) elem_app[i] = (run_q > DOT_MAX_C);
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    elem_d    = elem_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    len_d     = len_q;
    code_d    = code_q;
    emit      = 1'b0;
    emit_len  = cnt_q;
    emit_code = elem_q;

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (key_in) begin
            state_d = S_MARK;
            run_d   = RUN_ONE;
          end
        end
        S_MARK: begin
          if (key_in) begin
            if (run_inc > DASH_MAX_C) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              run_d   = '0;
              elem_d  = '0;
              cnt_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else if (cnt_q >= MAX_ELEMS_C) begin
            // The ending space tick already counts toward the recovery gap
            state_d = S_ERR;
            err_d   = 1'b1;
            run_d   = RUN_ONE;
            elem_d  = '0;
            cnt_d   = '0;
          end else if (GAP_LETTER <= 1) begin
            emit      = 1'b1;
            emit_len  = cnt_q + 3'd1;
            emit_code = elem_app;
          end else begin
            state_d = S_SPACE;
            run_d   = RUN_ONE;
            elem_d  = elem_app;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        S_SPACE: begin
          if (key_in) begin
            state_d = S_MARK;
            run_d   = RUN_ONE;
          end else if (run_inc >= GAP_C) begin
            emit = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        S_ERR: begin
          if (key_in) begin
            run_d = '0;
          end else if (run_inc >= GAP_C) begin
            state_d = S_IDLE;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (emit) begin
        state_d = S_IDLE;
        run_d   = '0;
        elem_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b1;
        len_d   = emit_len;
        code_d  = emit_code;
      end
    end
  end

`ifdef MORSE_RX_ASCII_EN
  always_comb begin
    ascii_d = ascii_q;
    if (valid_d) ascii_d = morse_ascii(len_d, code_d);
  end
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      elem_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      code_q  <= '0;
`ifdef MORSE_RX_ASCII_EN
      ascii_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      elem_q  <= elem_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      len_q   <= len_d;
      code_q  <= code_d;
`ifdef MORSE_RX_ASCII_EN
      ascii_q <= ascii_d;
`endif
    end
  end

  assign letter_valid = valid_q;
  assign err          = err_q;
  assign letter_len   = len_q;
  assign letter_code  = code_q;
  assign busy         = (state_q != S_IDLE);
`ifdef MORSE_RX_ASCII_EN
  assign letter_ascii = ascii_q;
`endif

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: run-length letter model checked every cycle, plus literal letter checks.
module tb_morse_receiver;

  localparam int DOT_MAX    = 2;
  localparam int DASH_MAX   = 5;
  localparam int GAP_LETTER = 3;
  localparam int MAX_ELEMS  = 4;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       tick;
  logic       key_in;
  logic       letter_valid;
  logic [2:0] letter_len;
  logic [3:0] letter_code;
  logic       err;
  logic       busy;
`ifdef MORSE_RX_ASCII_EN
  logic [7:0] letter_ascii;
`endif

  int checks   = 0;
  int failures = 0;

  morse_receiver #(
    .DOT_MAX    (DOT_MAX),
    .DASH_MAX   (DASH_MAX),
    .GAP_LETTER (GAP_LETTER),
    .MAX_ELEMS  (MAX_ELEMS),
    .CNT_W      (4)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .tick         (tick),
    .key_in       (key_in),
    .letter_valid (letter_valid),
    .letter_len   (letter_len),
    .letter_code  (letter_code),
    .err          (err),
`ifdef MORSE_RX_ASCII_EN
    .letter_ascii (letter_ascii),
`endif
    .busy         (busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: letters as run lengths of tick samples and a queue of elements
  bit       m_valid, m_err, m_errmode;
  int       m_len, m_code;
  int       m_mark, m_space, m_quiet;
  bit       m_elems[$];

  function automatic void m_reset();
    m_valid = 0; m_err = 0; m_errmode = 0;
    m_len = 0; m_code = 0;
    m_mark = 0; m_space = 0; m_quiet = 0;
    m_elems.delete();
  endfunction

  function automatic void m_emit();
    m_valid = 1;
    m_len   = m_elems.size();
    m_code  = 0;
    foreach (m_elems[i]) if (m_elems[i]) m_code += (1 << i);
    m_elems.delete();
    m_space = 0;
  endfunction

  function automatic void m_enter_err(input int quiet);
    m_errmode = 1; m_err = 1; m_quiet = quiet;
    m_mark = 0; m_space = 0;
    m_elems.delete();
  endfunction

  function automatic void m_step(input bit k);
    m_valid = 0; m_err = 0;
    if (m_errmode) begin
      if (k) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet >= GAP_LETTER) m_errmode = 0;
      end
    end else if (m_mark > 0) begin
      if (k) begin
        m_mark++;
        if (m_mark > DASH_MAX) m_enter_err(0);
      end else if (m_elems.size() == MAX_ELEMS) begin
        m_enter_err(1);
      end else begin
        m_elems.push_back(m_mark > DOT_MAX);
        m_mark  = 0;
        m_space = 1;
        if (m_space >= GAP_LETTER) m_emit();
      end
    end else if (m_elems.size() > 0) begin
      if (k) begin
        m_mark = 1; m_space = 0;
      end else begin
        m_space++;
        if (m_space >= GAP_LETTER) m_emit();
      end
    end else if (k) begin
      m_mark = 1;
    end
  endfunction

  function automatic bit m_busy();
    return m_errmode || (m_mark > 0) || (m_elems.size() > 0);
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge Clock or negedge Resetn);
      if (!Resetn) m_reset();
      else if (tick) m_step(key_in);
      else begin
        m_valid = 0; m_err = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      check("letter_valid", int'(letter_valid), int'(m_valid));
      check("err", int'(err), int'(m_err));
      check("busy", int'(busy), int'(m_busy()));
      check("letter_len", int'(letter_len), m_len);
      check("letter_code", int'(letter_code), m_code);
    end
  end

  task automatic apply(input bit k);
    @(negedge Clock);
    tick = 1'b1;
    key_in = k;
  endtask

  task automatic send(input logic [15:0] pat, input int n);
    logic [15:0] p;
    p = pat;
    for (int i = n - 1; i >= 0; i--) apply(p[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      tick = 1'b0;
      key_in = 1'b0;
    end
  endtask

  task automatic wait_letter(input string name, input int exp_len, input int exp_code,
                             input int exp_ascii);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge Clock);
      if (letter_valid) seen = 1;
    end
    check({name, "_seen"}, int'(seen), 1);
    check({name, "_len"}, int'(letter_len), exp_len);
    check({name, "_code"}, int'(letter_code), exp_code);
`ifdef MORSE_RX_ASCII_EN
    check({name, "_ascii"}, int'(letter_ascii), exp_ascii);
`else
    if (exp_ascii < 0) check({name, "_ascii_arg"}, exp_ascii, 0);
`endif
  endtask

  task automatic wait_err(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge Clock);
      if (err) seen = 1;
    end
    check({name, "_err_seen"}, int'(seen), 1);
  endtask

  initial begin
    Resetn = 1'b0;
    tick   = 1'b0;
    key_in = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_busy", int'(busy), 0);
    check("rst_len", int'(letter_len), 0);
    check("rst_code", int'(letter_code), 0);
    check("rst_valid", int'(letter_valid), 0);
    Resetn = 1'b1;
    idle(2);

    // A: dot, dash, letter gap
    send(16'b1011_1000, 8);
    wait_letter("A", 2, 4'b0010, 8'h41);
    idle(3);

    // H: four dots
    send(16'b10_1010_1000, 10);
    wait_letter("H", 4, 4'b0000, 8'h48);
    idle(3);

    // Overlong mark, then recovery gap
    send(16'b11_1111, 6);
    wait_err("long");
    send(16'b000, 3);
    @(negedge Clock);
    check("long_recover_busy", int'(busy), 0);
    check("long_no_letter", int'(letter_valid), 0);
    check("long_len_held", int'(letter_len), 4);
    idle(3);

    // Five dots overflow the element register
    send(16'b10_1010_1010, 10);
    wait_err("five");
    send(16'b000, 3);
    idle(2);
    check("five_busy", int'(busy), 0);
    check("five_code_held", int'(letter_code), 0);

    // Key pulses between ticks are invisible
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); tick = 1'b1; key_in = 1'b0;
      @(negedge Clock); tick = 1'b0; key_in = 1'b1;
      @(negedge Clock); key_in = 1'b1;
      @(negedge Clock); key_in = 1'b0;
    end
    idle(1);
    check("tickgate_busy", int'(busy), 0);

    // T then W via dash boundary (3 units) and max dash (5 units)
    send(16'b111_000, 6);
    wait_letter("T", 1, 4'b0001, 8'h54);
    idle(2);
    send(16'b10_1111_1011_1000, 14);
    wait_letter("W", 3, 4'b0110, 8'h57);
    idle(2);

    // Asynchronous reset mid-letter
    send(16'b10_1110, 6);
    @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_len", int'(letter_len), 0);
    check("async_code", int'(letter_code), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    send(16'b1000, 4);
    wait_letter("E", 1, 4'b0000, 8'h45);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
